// File: rtl/l1_snoop_responder_pkg.sv
// Shared coherence-bus message encodings, MESI line states and snoop FSM states.
package l1_snoop_responder_pkg;

   localparam int unsigned MsgW = 4;

   // Coherence bus messages
   localparam logic [MsgW-1:0] NO_REQ     = 4'd0;
   localparam logic [MsgW-1:0] R_REQ      = 4'd1;
   localparam logic [MsgW-1:0] WB_REQ     = 4'd2;
   localparam logic [MsgW-1:0] WS_BCAST   = 4'd3;
   localparam logic [MsgW-1:0] REQ_FLUSH  = 4'd4;
   localparam logic [MsgW-1:0] EN_ACCESS  = 4'd5;
   localparam logic [MsgW-1:0] C_WB       = 4'd6;
   localparam logic [MsgW-1:0] C_FLUSH    = 4'd7;
   localparam logic [MsgW-1:0] MEM_RESP   = 4'd8;
   localparam logic [MsgW-1:0] MEM_C_RESP = 4'd9;
   localparam logic [MsgW-1:0] HOLD_BUS   = 4'd10;

   // MESI line states
   localparam logic [1:0] MESI_I = 2'd0;
   localparam logic [1:0] MESI_S = 2'd1;
   localparam logic [1:0] MESI_E = 2'd2;
   localparam logic [1:0] MESI_M = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StRespond,
      StWaitGrant,
      StTransfer,
      StWaitEnd
   } snoop_state_e;

endpackage

// File: rtl/l1_snoop_responder.sv
// Snoop engine for one L1 cache: looks up peer bus requests in the local tag array,
// downgrades/invalidates the line, and writes back or flushes a dirty line when needed.
module l1_snoop_responder
   import l1_snoop_responder_pkg::*;
#(
   parameter int unsigned MSG_BITS      = 4,
   parameter int unsigned NUM_CACHES    = 4,
   parameter int unsigned CACHE_ID      = 0,
   parameter int unsigned ADDRESS_BITS  = 32,
   parameter int unsigned BUS_SIG_WIDTH = $clog2(NUM_CACHES + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [MSG_BITS-1:0]      bus_msg,
   input  logic [ADDRESS_BITS-1:0]  bus_address,
   input  logic [BUS_SIG_WIDTH-1:0] bus_control,
   input  logic                     bus_en,
   input  logic                     req_ready,
   output logic [MSG_BITS-1:0]      snoop_msg,
   output logic                     snoop_active,
   output logic                     lookup_en,
   output logic [ADDRESS_BITS-1:0]  lookup_address,
   input  logic                     lookup_valid,
   input  logic                     lookup_hit,
   input  logic [1:0]               lookup_state,
   output logic                     upd_en,
   output logic [1:0]               upd_state,
   output logic                     line_out_en
);

   localparam logic [BUS_SIG_WIDTH-1:0] OwnId = BUS_SIG_WIDTH'(CACHE_ID);

   localparam logic [MSG_BITS-1:0] MNoReq    = MSG_BITS'(NO_REQ);
   localparam logic [MSG_BITS-1:0] MRReq     = MSG_BITS'(R_REQ);
   localparam logic [MSG_BITS-1:0] MWsBcast  = MSG_BITS'(WS_BCAST);
   localparam logic [MSG_BITS-1:0] MReqFlush = MSG_BITS'(REQ_FLUSH);
   localparam logic [MSG_BITS-1:0] MEnAccess = MSG_BITS'(EN_ACCESS);
   localparam logic [MSG_BITS-1:0] MCWb      = MSG_BITS'(C_WB);
   localparam logic [MSG_BITS-1:0] MCFlush   = MSG_BITS'(C_FLUSH);
   localparam logic [MSG_BITS-1:0] MMemCResp = MSG_BITS'(MEM_C_RESP);

   snoop_state_e              state_q;
   logic [MSG_BITS-1:0]       req_msg_q;
   logic [MSG_BITS-1:0]       snoop_msg_q;
   logic                      active_q;
   logic                      issued_q;
   logic                      upd_en_q;
   logic [1:0]                upd_state_q;
   logic                      line_out_q;
   logic [ADDRESS_BITS-1:0]   addr_q;

   logic peer_master;
   logic trigger;
   logic line_valid;
   logic line_dirty;

   // Decode the snoop trigger and the usable lookup result
   always_comb begin
      peer_master = (bus_control != OwnId);
      trigger     = bus_en && peer_master &&
                    ((bus_msg == MRReq) || (bus_msg == MWsBcast) || (bus_msg == MReqFlush));
      // A hit reporting state I carries no data and is treated as a miss
      line_valid  = lookup_hit && (lookup_state != MESI_I);
      line_dirty  = line_valid && (lookup_state == MESI_M);
   end

   // Snoop FSM with registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         req_msg_q   <= MNoReq;
         snoop_msg_q <= MNoReq;
         active_q    <= 1'b0;
         issued_q    <= 1'b0;
         upd_en_q    <= 1'b0;
         upd_state_q <= MESI_I;
         line_out_q  <= 1'b0;
         addr_q      <= '0;
      end else begin
         upd_en_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (trigger) begin
                  state_q   <= StLookup;
                  req_msg_q <= bus_msg;
                  addr_q    <= bus_address;
                  active_q  <= 1'b1;
                  issued_q  <= 1'b0;
               end
            end
            StLookup: begin
               issued_q <= 1'b1;
               if (lookup_valid) begin
                  state_q     <= StRespond;
                  snoop_msg_q <= MEnAccess;
                  if (req_msg_q == MRReq) begin
                     if (line_dirty) begin
                        state_q     <= StWaitGrant;
                        snoop_msg_q <= MCWb;
                     end else if (line_valid && (lookup_state == MESI_E)) begin
                        upd_en_q    <= 1'b1;
                        upd_state_q <= MESI_S;
                     end
                  end else if (req_msg_q == MWsBcast) begin
                     if (line_valid) begin
                        upd_en_q    <= 1'b1;
                        upd_state_q <= MESI_I;
                     end
                  end else begin
                     if (line_dirty) begin
                        state_q     <= StWaitGrant;
                        snoop_msg_q <= MCFlush;
                     end else if (line_valid) begin
                        upd_en_q    <= 1'b1;
                        upd_state_q <= MESI_I;
                     end
                  end
               end
            end
            StWaitGrant: begin
               if (bus_en && !peer_master) begin
                  state_q    <= StTransfer;
                  line_out_q <= 1'b1;
               end
            end
            StTransfer: begin
               if (bus_msg == MMemCResp) begin
                  state_q     <= StRespond;
                  line_out_q  <= 1'b0;
                  snoop_msg_q <= MEnAccess;
                  upd_en_q    <= 1'b1;
                  upd_state_q <= (req_msg_q == MRReq) ? MESI_S : MESI_I;
               end
            end
            StRespond: begin
               if (req_ready || ((bus_msg == MNoReq) && peer_master)) begin
                  state_q     <= StWaitEnd;
                  snoop_msg_q <= MNoReq;
                  active_q    <= 1'b0;
               end
            end
            StWaitEnd: begin
               // Hold off until the bus drops the transaction so it cannot re-trigger
               if (bus_msg == MNoReq) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               snoop_msg_q <= MNoReq;
               active_q    <= 1'b0;
               line_out_q  <= 1'b0;
            end
         endcase
      end
   end

   assign lookup_en      = (state_q == StLookup) && !issued_q;
   assign snoop_msg      = snoop_msg_q;
   assign snoop_active   = active_q;
   assign lookup_address = addr_q;
   assign upd_en         = upd_en_q;
   assign upd_state      = upd_state_q;
   assign line_out_en    = line_out_q;

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Directed bench for l1_snoop_responder: table of single-lookup snoops plus
// hand-written writeback, flush and reset-in-transfer sequences.
module tb_l1_snoop_responder;
   import l1_snoop_responder_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  bus_msg;
   logic [31:0] bus_address;
   logic [2:0]  bus_control;
   logic        bus_en;
   logic        req_ready;
   logic [3:0]  snoop_msg;
   logic        snoop_active;
   logic        lookup_en;
   logic [31:0] lookup_address;
   logic        lookup_valid;
   logic        lookup_hit;
   logic [1:0]  lookup_state;
   logic        upd_en;
   logic [1:0]  upd_state;
   logic        line_out_en;

   int checks = 0;
   int errors = 0;

   l1_snoop_responder #(
      .MSG_BITS(4), .NUM_CACHES(4), .CACHE_ID(0), .ADDRESS_BITS(32), .BUS_SIG_WIDTH(3)
   ) dut (
      .clock(clock), .reset(reset), .bus_msg(bus_msg), .bus_address(bus_address),
      .bus_control(bus_control), .bus_en(bus_en), .req_ready(req_ready),
      .snoop_msg(snoop_msg), .snoop_active(snoop_active), .lookup_en(lookup_en),
      .lookup_address(lookup_address), .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
      .lookup_state(lookup_state), .upd_en(upd_en), .upd_state(upd_state),
      .line_out_en(line_out_en)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  msg;
      logic [2:0]  ctrl;
      logic        en;
      logic [31:0] addr;
      logic        hit;
      logic [1:0]  st;
      int          lat;      // 0: lookup_valid with lookup_en, 1: one cycle later
      int          rel;      // 0: req_ready, 1: bus NO_REQ, 2: both
      logic        exp_trig;
      logic        exp_upd;
      logic [1:0]  exp_st;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_snoop_msg"}, 32'(snoop_msg), 32'(NO_REQ));
      check({tag, "_active"}, 32'(snoop_active), 0);
      check({tag, "_lookup_en"}, 32'(lookup_en), 0);
      check({tag, "_upd_en"}, 32'(upd_en), 0);
      check({tag, "_upd_state"}, 32'(upd_state), 0);
      check({tag, "_line_out"}, 32'(line_out_en), 0);
      check({tag, "_addr"}, lookup_address, 0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      bus_en = v.en; bus_control = v.ctrl; bus_msg = v.msg; bus_address = v.addr;
      tick();
      if (!v.exp_trig) begin
         check({t, "_no_lookup_en"}, 32'(lookup_en), 0);
         check({t, "_no_active"}, 32'(snoop_active), 0);
         tick();
         check({t, "_no_snoop"}, 32'(snoop_msg), 32'(NO_REQ));
         bus_msg = NO_REQ; bus_en = 1'b0;
         tick();
         return;
      end
      check({t, "_lookup_en"}, 32'(lookup_en), 1);
      check({t, "_lookup_addr"}, lookup_address, v.addr);
      check({t, "_active"}, 32'(snoop_active), 1);
      check({t, "_pre_msg"}, 32'(snoop_msg), 32'(NO_REQ));
      lookup_hit = v.hit; lookup_state = v.st;
      if (v.lat == 0) lookup_valid = 1'b1;
      tick();
      if (v.lat != 0) begin
         check({t, "_lookup_en_once"}, 32'(lookup_en), 0);
         lookup_valid = 1'b1;
         tick();
      end
      lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_state = MESI_I;
      check({t, "_resp"}, 32'(snoop_msg), 32'(EN_ACCESS));
      check({t, "_upd_en"}, 32'(upd_en), 32'(v.exp_upd));
      if (v.exp_upd) check({t, "_upd_state"}, 32'(upd_state), 32'(v.exp_st));
      check({t, "_line_out"}, 32'(line_out_en), 0);
      if (v.rel != 1) req_ready = 1'b1;
      if (v.rel != 0) bus_msg = NO_REQ;
      tick();
      req_ready = 1'b0;
      check({t, "_upd_pulse_end"}, 32'(upd_en), 0);
      check({t, "_rel_msg"}, 32'(snoop_msg), 32'(NO_REQ));
      check({t, "_rel_active"}, 32'(snoop_active), 0);
      if (v.rel == 0) begin
         // Bus still carries the request: must not snoop it a second time
         tick();
         check({t, "_no_retrigger"}, 32'(lookup_en), 0);
         bus_msg = NO_REQ;
      end
      tick();
      bus_en = 1'b0;
      tick();
   endtask

   // Trigger a snoop and answer its lookup one cycle after lookup_en
   task automatic start_snoop(input logic [3:0] msg, input logic [2:0] ctrl,
                              input logic [31:0] addr, input logic [1:0] st);
      bus_en = 1'b1; bus_control = ctrl; bus_msg = msg; bus_address = addr;
      tick();
      check("hs_lookup_en", 32'(lookup_en), 1);
      tick();
      lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_state = st;
      tick();
      lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_state = MESI_I;
   endtask

   // Writeback/flush of an M line: wait for grant, transfer, then EN_ACCESS
   task automatic dirty_seq(input string t, input logic [3:0] msg, input logic [2:0] ctrl,
                            input logic [3:0] exp_c, input logic [1:0] exp_st);
      start_snoop(msg, ctrl, 32'h0000_0080, MESI_M);
      check({t, "_cmsg"}, 32'(snoop_msg), 32'(exp_c));
      check({t, "_no_upd"}, 32'(upd_en), 0);
      bus_msg = MEM_C_RESP;  // not in TRANSFER yet: ignored
      for (int i = 0; i < 3; i++) begin
         tick();
         check({t, "_hold"}, 32'(snoop_msg), 32'(exp_c));
         check({t, "_no_line_out"}, 32'(line_out_en), 0);
         check({t, "_no_early_upd"}, 32'(upd_en), 0);
      end
      bus_msg = NO_REQ; bus_control = 3'd0;
      tick();
      check({t, "_line_out"}, 32'(line_out_en), 1);
      check({t, "_xfer_msg"}, 32'(snoop_msg), 32'(exp_c));
      tick();
      check({t, "_line_out_hold"}, 32'(line_out_en), 1);
      bus_msg = MEM_C_RESP;
      tick();
      bus_msg = R_REQ;
      check({t, "_upd_en"}, 32'(upd_en), 1);
      check({t, "_upd_state"}, 32'(upd_state), 32'(exp_st));
      check({t, "_resp"}, 32'(snoop_msg), 32'(EN_ACCESS));
      check({t, "_line_out_off"}, 32'(line_out_en), 0);
      tick();
      check({t, "_upd_once"}, 32'(upd_en), 0);
      check({t, "_still_resp"}, 32'(snoop_msg), 32'(EN_ACCESS));
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check({t, "_end_msg"}, 32'(snoop_msg), 32'(NO_REQ));
      check({t, "_end_active"}, 32'(snoop_active), 0);
      bus_msg = NO_REQ; bus_en = 1'b0;
      tick();
      tick();
   endtask

   vec_t vecs[13];

   initial begin
      //          msg        ctrl en addr           hit st     lat rel trig upd st
      vecs[0]  = '{R_REQ,     3'd2, 1, 32'h0000_0040, 0, MESI_I, 1, 0, 1, 0, MESI_I};
      vecs[1]  = '{R_REQ,     3'd2, 1, 32'h0000_0044, 1, MESI_I, 0, 1, 1, 0, MESI_I};
      vecs[2]  = '{R_REQ,     3'd3, 1, 32'h0000_1000, 1, MESI_S, 1, 2, 1, 0, MESI_I};
      vecs[3]  = '{R_REQ,     3'd1, 1, 32'h0000_2040, 1, MESI_E, 1, 0, 1, 1, MESI_S};
      vecs[4]  = '{WS_BCAST,  3'd1, 1, 32'h0000_3000, 1, MESI_S, 1, 1, 1, 1, MESI_I};
      vecs[5]  = '{WS_BCAST,  3'd2, 1, 32'h0000_3040, 0, MESI_I, 0, 0, 1, 0, MESI_I};
      vecs[6]  = '{WS_BCAST,  3'd3, 1, 32'h0000_3080, 1, MESI_E, 0, 2, 1, 1, MESI_I};
      vecs[7]  = '{REQ_FLUSH, 3'd4, 1, 32'h0000_4000, 1, MESI_S, 1, 0, 1, 1, MESI_I};
      vecs[8]  = '{REQ_FLUSH, 3'd4, 1, 32'h0000_4040, 1, MESI_E, 0, 1, 1, 1, MESI_I};
      vecs[9]  = '{REQ_FLUSH, 3'd4, 1, 32'h0000_4080, 0, MESI_I, 1, 0, 1, 0, MESI_I};
      vecs[10] = '{R_REQ,     3'd0, 1, 32'h0000_5000, 0, MESI_I, 1, 0, 0, 0, MESI_I};
      vecs[11] = '{WB_REQ,    3'd3, 1, 32'h0000_5040, 0, MESI_I, 1, 0, 0, 0, MESI_I};
      vecs[12] = '{REQ_FLUSH, 3'd2, 0, 32'h0000_5080, 0, MESI_I, 1, 0, 0, 0, MESI_I};

      reset = 1'b1; bus_msg = NO_REQ; bus_address = '0; bus_control = 3'd4; bus_en = 1'b0;
      req_ready = 1'b0; lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_state = MESI_I;
      #1;
      check_idle_outputs("reset");
      tick();
      tick();
      reset = 1'b0;
      tick();

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      dirty_seq("wb", R_REQ, 3'd2, C_WB, MESI_S);
      dirty_seq("flush", REQ_FLUSH, 3'd4, C_FLUSH, MESI_I);

      // Asynchronous reset while the line is being transferred
      start_snoop(R_REQ, 3'd2, 32'h0000_00c0, MESI_M);
      bus_control = 3'd0;
      tick();
      check("rst_pre_line_out", 32'(line_out_en), 1);
      #2 reset = 1'b1;
      #1;
      check_idle_outputs("rst_async");
      bus_en = 1'b0; bus_msg = NO_REQ;
      tick();
      reset = 1'b0;
      tick();
      run_vec(vecs[0], 20);
      run_vec(vecs[3], 21);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
